// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared FSM/phase types, default port addresses and status decode for the IO bus master
package io_bus_pkg;
    localparam logic [15:0] DEF_DATA_ADDR = 16'h0800;
    localparam logic [15:0] DEF_STAT_ADDR = 16'h0A00;
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STROBE, RD_HOLD, CHECK, WR_SETUP, WR_STROBE, WR_HOLD
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;
    // All-ones usually means a floating bus, so it is never trusted as "ready"
    function automatic logic status_busy(input logic [7:0] s, input logic [7:0] m);
        return (s & m) != 8'h00 || s == 8'hFF;
    endfunction
    function automatic state_t phase_state(input phase_t ph, input logic wr, input state_t done);
        return ph == PH_SETUP  ? (wr ? WR_SETUP  : RD_SETUP)  :
               ph == PH_STROBE ? (wr ? WR_STROBE : RD_STROBE) :
               ph == PH_HOLD   ? (wr ? WR_HOLD   : RD_HOLD)   : done;
    endfunction
endpackage

// File: rtl/io_bus_cycle.sv
// io_bus_cycle: one SETUP/STROBE/HOLD bus cycle (read or write) with registered strobes
module io_bus_cycle
    import io_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic [7:0]  i_data_in,
    output phase_t      o_phase_nxt,
    output logic [7:0]  o_rdata,
    output logic [15:0] o_address,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic        o_cs_n,
    output logic        o_we_n,
    output logic        o_oe_n
);
    phase_t      r_phase;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        w_load, w_last, w_write, w_act, w_strobe;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    assign w_load      = r_phase == PH_IDLE && i_start;
    assign w_last      = r_phase == PH_STROBE && r_cnt == 4'(STROBE_CYCLES - 1);
    assign o_phase_nxt = w_load ? PH_SETUP :
                         r_phase == PH_SETUP  ? PH_STROBE :
                         r_phase == PH_STROBE ? (w_last ? PH_HOLD : PH_STROBE) : PH_IDLE;
    assign w_write  = w_load ? i_write : r_write;
    assign w_addr   = w_load ? i_addr  : r_addr;
    assign w_wdata  = w_load ? i_wdata : r_wdata;
    assign w_act    = o_phase_nxt != PH_IDLE;
    assign w_strobe = o_phase_nxt == PH_STROBE;
    // Pins are registered from the next phase so they change cleanly with the state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_phase    <= PH_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            o_rdata    <= '0;
            o_address  <= '0;
            o_data_out <= '0;
            o_data_oe  <= 1'b0;
            o_cs_n     <= 1'b1;
            o_we_n     <= 1'b1;
            o_oe_n     <= 1'b1;
        end else begin
            r_phase    <= o_phase_nxt;
            r_cnt      <= (w_last || r_phase != PH_STROBE) ? 4'd0 : r_cnt + 4'd1;
            r_write    <= w_write;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            o_rdata    <= (w_last && !r_write) ? i_data_in : o_rdata;
            o_address  <= w_act ? w_addr : '0;
            o_data_out <= (w_act && w_write) ? w_wdata : '0;
            o_data_oe  <= w_act && w_write;
            o_cs_n     <= !w_act;
            o_we_n     <= !(w_strobe && w_write);
            o_oe_n     <= !(w_strobe && !w_write);
        end
    end
endmodule

// File: rtl/io_tx_master.sv
// io_tx_master: streams bytes to a polled UART over an async-strobe IO bus, polling status before each write
module io_tx_master
    import io_bus_pkg::*;
#(
    parameter logic [15:0] DATA_ADDR     = DEF_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR     = DEF_STAT_ADDR,
    parameter logic [7:0]  BUSY_MASK     = 8'h01,
    parameter int          STROBE_CYCLES = 2,
    parameter int          POLL_MAX      = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] io_address,
    output logic [7:0]  io_data_out,
    output logic        io_data_oe,
    input  logic [7:0]  io_data_in,
    output logic        io_cs_n,
    output logic        io_we_n,
    output logic        io_oe_n,
    output logic        busy,
    output logic        timeout_err
);
    state_t     r_state, w_state_nxt;
    phase_t     w_phase_nxt;
    logic [7:0] r_byte, r_poll, w_status;
    logic       w_accept, w_busy_st, w_give_up, w_start, w_write;
    assign w_accept  = r_state == IDLE && in_valid && in_ready;
    assign w_busy_st = status_busy(w_status, BUSY_MASK);
    assign w_give_up = r_state == CHECK && w_busy_st && r_poll + 8'd1 == 8'(POLL_MAX);
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:                        w_state_nxt = w_accept ? RD_SETUP : IDLE;
            CHECK:                       w_state_nxt = !w_busy_st ? WR_SETUP : w_give_up ? IDLE : RD_SETUP;
            RD_SETUP, RD_STROBE, RD_HOLD: w_state_nxt = phase_state(w_phase_nxt, 1'b0, CHECK);
            default:                     w_state_nxt = phase_state(w_phase_nxt, 1'b1, IDLE);
        endcase
    end
    always_comb begin
        w_start = w_accept || (r_state == CHECK && !w_give_up);
        w_write = r_state == CHECK && !w_busy_st;
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            r_poll      <= '0;
            r_byte      <= '0;
        end else begin
            in_ready    <= w_state_nxt == IDLE;
            busy        <= w_state_nxt != IDLE;
            timeout_err <= w_give_up;
            r_poll      <= w_accept ? 8'd0 : (r_state == CHECK && w_busy_st) ? r_poll + 8'd1 : r_poll;
            r_byte      <= w_accept ? in_data : r_byte;
        end
    end
    io_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_cycle (
        .clk         (clk),
        .nreset      (nreset),
        .i_start     (w_start),
        .i_write     (w_write),
        .i_addr      (w_write ? DATA_ADDR : STAT_ADDR),
        .i_wdata     (r_byte),
        .i_data_in   (io_data_in),
        .o_phase_nxt (w_phase_nxt),
        .o_rdata     (w_status),
        .o_address   (io_address),
        .o_data_out  (io_data_out),
        .o_data_oe   (io_data_oe),
        .o_cs_n      (io_cs_n),
        .o_we_n      (io_we_n),
        .o_oe_n      (io_oe_n)
    );
endmodule

// File: tb/tb_io_tx_master.sv
// tb_io_tx_master: directed and randomized checks of io_tx_master against a bus responder and status-poll model
module tb_io_tx_master;
    localparam int POLL = 4;
    logic        clk = 1'b0, nreset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, io_data_oe, io_cs_n, io_we_n, io_oe_n, busy, timeout_err;
    logic [15:0] io_address;
    logic [7:0]  io_data_out;
    logic [7:0]  io_data_in = 8'h00;
    int          vectors = 0, miscompares = 0;
    logic [7:0]  seq[$];
    logic [7:0]  dflt = 8'h00;
    int          st_idx = 0, n_reads = 0, n_to = 0;
    logic [7:0]  wr_log[$];
    logic        prev_oe = 1'b1, prev_we = 1'b1;

    io_tx_master #(.POLL_MAX(POLL)) dut (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .io_address(io_address), .io_data_out(io_data_out), .io_data_oe(io_data_oe),
        .io_data_in(io_data_in), .io_cs_n(io_cs_n), .io_we_n(io_we_n), .io_oe_n(io_oe_n),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stat_at(input int i);
        return i < seq.size() ? seq[i] : dflt;
    endfunction

    // Reference: the UART accepts a byte on the first read whose status is neither FF nor has bit 0 set
    task automatic predict(output int reads, output int writes);
        reads = 0;
        writes = 0;
        for (int n = 0; n < POLL; n++) begin
            logic [7:0] s;
            s = stat_at(n);
            reads = n + 1;
            if (s[0] == 1'b0 && s != 8'hFF) begin
                writes = 1;
                break;
            end
        end
    endtask

    task automatic start_test();
        st_idx = 0;
        io_data_in = stat_at(0);
        n_reads = 0;
        n_to = 0;
        wr_log.delete();
    endtask

    // Bus responder / monitor, sampled on the falling edge
    always @(negedge clk) begin
        chk("oe_we_overlap", !(!io_oe_n && !io_we_n), 1);
        chk("oe_while_drive", !io_data_oe || io_oe_n, 1);
        chk("dout_idle_zero", io_data_oe || io_data_out == 8'h00, 1);
        chk("addr_idle_zero", !io_cs_n || io_address == 16'h0000, 1);
        if (nreset) begin
            if (!io_oe_n && prev_oe) begin
                n_reads++;
                chk("rd_addr", io_address, 16'h0A00);
            end
            if (io_oe_n && !prev_oe && !io_cs_n) begin
                st_idx++;
                io_data_in = stat_at(st_idx);
            end
            if (io_we_n && !prev_we && !io_cs_n) begin
                wr_log.push_back(io_data_out);
                chk("wr_addr", io_address, 16'h0800);
                chk("wr_oe", io_data_oe, 1);
            end
            if (timeout_err) n_to++;
        end
        prev_oe = io_oe_n;
        prev_we = io_we_n;
    end

    task automatic send(input logic [7:0] b);
        int t;
        in_data = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", t < 500, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || !in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", t < 2000, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [8:0] log_at(input int i);
        return i < wr_log.size() ? {1'b0, wr_log[i]} : 9'h100;
    endfunction

    initial begin
        int er, ew;
        logic [7:0] msg[3];
        logic [7:0] pool[6];
        msg  = '{8'h48, 8'h69, 8'h0A};
        pool = '{8'h00, 8'h01, 8'hFF, 8'h03, 8'h02, 8'h80};
        // Reset state
        start_test();
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {io_cs_n, io_oe_n, io_we_n}, 3'b111);
        chk("rst_data_oe", io_data_oe, 0);
        chk("rst_addr", io_address, 0);
        chk("rst_dout", io_data_out, 0);
        chk("rst_timeout", timeout_err, 0);
        #2 nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", in_ready, 1);
        // Status always 00, send 41: cycle-exact bus timeline
        seq.delete();
        dflt = 8'h00;
        start_test();
        @(negedge clk);
        in_data = 8'h41;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("c%0d_cs_n", c), io_cs_n, !((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
            chk($sformatf("c%0d_oe_n", c), io_oe_n, !(c == 2 || c == 3));
            chk($sformatf("c%0d_we_n", c), io_we_n, !(c == 7 || c == 8));
            chk($sformatf("c%0d_data_oe", c), io_data_oe, c >= 6 && c <= 9);
            chk($sformatf("c%0d_in_ready", c), in_ready, c == 10);
            if (c == 1) chk("c1_addr", io_address, 16'h0A00);
            if (c == 5) chk("c5_addr", io_address, 16'h0000);
            if (c == 7) chk("c7_addr_data", {io_address, io_data_out}, 24'h080041);
        end
        chk("t1_reads", n_reads, 1);
        chk("t1_writes", wr_log.size(), 1);
        chk("t1_byte", log_at(0), 9'h041);
        // Busy twice then ready
        seq = '{8'h01, 8'h01};
        dflt = 8'h00;
        start_test();
        send(8'h0D);
        in_valid = 1'b0;
        wait_idle();
        chk("t2_reads", n_reads, 3);
        chk("t2_writes", wr_log.size(), 1);
        chk("t2_byte", log_at(0), 9'h00D);
        chk("t2_timeout", n_to, 0);
        // Status stuck at FF: timeout after POLL reads
        seq.delete();
        dflt = 8'hFF;
        start_test();
        send(8'h55);
        in_valid = 1'b0;
        wait_idle();
        chk("t3_reads", n_reads, POLL);
        chk("t3_writes", wr_log.size(), 0);
        chk("t3_timeout_pulse", n_to, 1);
        chk("t3_in_ready", in_ready, 1);
        // Back-to-back stream; in_data moves on while busy and must not be picked up
        dflt = 8'h00;
        start_test();
        for (int i = 0; i < 3; i++) send(msg[i]);
        in_valid = 1'b0;
        wait_idle();
        chk("t4_writes", wr_log.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t4_byte%0d", i), log_at(i), {1'b0, msg[i]});
        // Randomized status scripts against the poll model
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            seq.delete();
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) seq.push_back(pool[$urandom_range(0, 5)]);
            dflt = pool[$urandom_range(0, 2)];
            b = 8'($urandom);
            start_test();
            predict(er, ew);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(b);
            in_valid = 1'b0;
            wait_idle();
            chk($sformatf("r%0d_reads", k), n_reads, er);
            chk($sformatf("r%0d_writes", k), wr_log.size(), ew);
            chk($sformatf("r%0d_timeout", k), n_to, 1 - ew);
            chk($sformatf("r%0d_byte", k), log_at(0), ew == 1 ? {1'b0, b} : 9'h100);
        end
        // Reset during the write strobe drops the byte and releases the bus at once
        seq.delete();
        dflt = 8'h00;
        start_test();
        send(8'h77);
        in_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (io_we_n && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("t6_we_seen", t < 200, 1);
        end
        #2 nreset = 1'b0;
        #1;
        chk("t6_strobes", {io_cs_n, io_oe_n, io_we_n}, 3'b111);
        chk("t6_data_oe", io_data_oe, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rdy_after", in_ready, 1);
        repeat (20) @(negedge clk);
        chk("t6_no_write", wr_log.size(), 0);
        chk("t6_bus_idle", io_cs_n, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_tx_master.md
IO_TX_MASTER -- requirements
Module: io_tx_master

Interface
REQ-001 SHALL have parameter DATA_ADDR, default 16'h0800, meaning the UART data port address.
REQ-002 SHALL have parameter STAT_ADDR, default 16'h0A00, meaning the UART status port address.
REQ-003 SHALL have parameter BUSY_MASK, default 8'h01, meaning the status bits that mean "UART busy".
REQ-004 SHALL have parameter STROBE_CYCLES, default 2, legal range 1..15, meaning the OE_n/WE_n low time in cycles.
REQ-005 SHALL have parameter POLL_MAX, default 255, legal range 1..255, meaning the maximum status reads per byte.
REQ-006 SHALL have ports clk in 1 (the single clock) and nreset in 1 (asynchronous, active-low reset).
REQ-007 SHALL have ports in_data in 8, in_valid in 1 and in_ready out 1, forming the character stream with a valid/ready handshake.
REQ-008 SHALL have ports io_address out 16, io_data_out out 8, io_data_oe out 1 (drive enable for io_data_out) and io_data_in in 8 (the sampled bus).
REQ-009 SHALL have ports io_cs_n, io_we_n and io_oe_n, each out 1, as the active-low IO bus strobes.
REQ-010 SHALL have ports busy out 1 (not IDLE) and timeout_err out 1 (one-cycle pulse).

Function
REQ-011 SHALL implement the FSM states IDLE, RD_SETUP, RD_STROBE, RD_HOLD, CHECK, WR_SETUP, WR_STROBE and WR_HOLD.
REQ-012 SHALL drive in_ready=1 only in IDLE; a byte is accepted when in_valid&&in_ready at a clock edge, latched, and the FSM goes to RD_SETUP.
REQ-013 SHALL drive, in RD_SETUP (1 cycle): io_address=STAT_ADDR, io_cs_n=0, io_oe_n=1, io_we_n=1.
REQ-014 SHALL hold io_oe_n=0 with cs asserted in RD_STROBE for STROBE_CYCLES cycles, and register io_data_in on the last strobe cycle.
REQ-015 SHALL hold io_oe_n=1 and io_cs_n=0 in RD_HOLD (1 cycle), then go to CHECK, where io_cs_n=1.
REQ-016 SHALL, in CHECK, go to WR_SETUP if (status & BUSY_MASK)==0; a status of 8'hFF counts as busy.
REQ-017 SHALL, in CHECK with busy status, increment an 8-bit poll counter; if it reaches POLL_MAX, drop the byte, pulse timeout_err for 1 cycle and go to IDLE; otherwise go to RD_SETUP.
REQ-018 SHALL drive, in WR_SETUP (1 cycle): io_address=DATA_ADDR, io_data_out=latched byte, io_data_oe=1, io_cs_n=0, io_we_n=1.
REQ-019 SHALL hold io_we_n=0 in WR_STROBE for STROBE_CYCLES cycles with address and data stable.
REQ-020 SHALL, in WR_HOLD (1 cycle), drive io_we_n=1 while io_data_oe=1 and io_cs_n=0, then go to IDLE.
REQ-021 SHALL clear the poll counter on every byte acceptance.
REQ-022 SHALL never assert io_oe_n=0 and io_we_n=0 in the same cycle.
REQ-023 SHALL never assert io_data_oe=1 outside WR_* states.
REQ-024 SHALL drive all strobes from registers (glitch-free).
REQ-025 SHALL have, with defaults and a non-busy status, acceptance in cycle 0, read cs low in cycles 1-4 (oe low 2-3), CHECK in cycle 5, write cs low in cycles 6-9 (we low 7-8), and in_ready=1 in cycle 10.
REQ-026 SHALL drive io_address to 16'h0000 in IDLE and CHECK.
REQ-027 SHALL drive io_data_out to 8'h00 when io_data_oe=0.
REQ-028 SHALL ignore in_valid in any non-IDLE state; the held byte is not overwritten.

Reset
REQ-029 SHALL, while nreset=0, asynchronously force: state=IDLE, io_cs_n=io_we_n=io_oe_n=1, io_data_oe=0, io_address=0, io_data_out=0, in_ready=0, busy=0, timeout_err=0, poll counter=0, latched byte=0.
REQ-030 SHALL raise in_ready in the first cycle after nreset deasserts.
REQ-031 SHALL, on reset mid-cycle, abort the transfer with all strobes released immediately; the held byte is lost.

Structure
REQ-032 SHALL place the FSM state enum and default DATA_ADDR/STAT_ADDR constants in shared package io_bus_pkg.
REQ-033 SHALL factor the bus-cycle sequencing (SETUP/STROBE/HOLD timing, read or write) into one sub-module, io_bus_cycle, reused for both cycle types.

Verification
REQ-034 SHALL verify: responder status always 00, send 8'h41 -> one read of 0A00, one write of 8'h41 to 0800, in_ready returns in cycle 10.
REQ-035 SHALL verify: status reads 01 twice then 00, send 8'h0D -> exactly 3 status reads, then 1 write of 8'h0D.
REQ-036 SHALL verify: status stuck at FF, POLL_MAX=4 -> 4 reads, a timeout_err 1-cycle pulse, no write, then in_ready=1.
REQ-037 SHALL verify: back-to-back in_valid with "Hi\n" -> 3 writes in order 48,69,0A, with no byte lost or duplicated.
REQ-038 SHALL verify: nreset pulsed during WR_STROBE -> strobes high and io_data_oe=0 within the same cycle, and no write is logged.
REQ-039 SHALL verify, via an assertion across all tests: never io_oe_n==0 && io_we_n==0; io_data_oe implies io_oe_n==1.
